display_update_scheduler: RTL and testbench

// Sits between the three measurement producers (range, doppler velocity, beam angle) and

---
 rtl/display_sched_pkg.sv | 43 ++++
 rtl/display_update_scheduler_rr_arbiter3.sv | 66 ++++++
 rtl/display_update_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_display_update_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// ---------------------------------------------------------------------------
// display_sched_pkg
// Shared types and constants for the display update scheduler:
//   - sched_state_t   : scheduler FSM states (WAIT_ALL, RUN)
//   - SRC_*           : bit positions of the three measurement sources
//   - DIST_MAX, VEL_MAX, ANG_LIM : clamp limits for displayable values
//   - clamp_u16 / clamp_angle    : clamp helpers used on shadow writes
// ---------------------------------------------------------------------------
package display_sched_pkg;

    typedef enum logic {
        WAIT_ALL = 1'b0,
        RUN      = 1'b1
    } sched_state_t;

    localparam int SRC_DIST = 0;
    localparam int SRC_VEL  = 1;
    localparam int SRC_ANG  = 2;
    localparam int NUM_SRC  = 3;

    localparam logic [15:0] DIST_MAX = 16'd255;
    localparam logic [15:0] VEL_MAX  = 16'd15;
    localparam int          ANG_LIM  = 90;

    // Unsigned saturation to an upper limit.
    function automatic logic [15:0] clamp_u16(input logic [15:0] value, input logic [15:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    // Signed clamp to [-ANG_LIM, ANG_LIM] so that (90 - angle) always lands in 0..180.
    function automatic logic [7:0] clamp_angle(input logic signed [7:0] angle);
        logic [7:0] result;
        if (int'(angle) > ANG_LIM) begin
            result = 8'(ANG_LIM);
        end else if (int'(angle) < -ANG_LIM) begin
            result = 8'(-ANG_LIM);
        end else begin
            result = angle;
        end
        return result;
    endfunction

endpackage

// File: rtl/display_update_scheduler_rr_arbiter3.sv
// ---------------------------------------------------------------------------
// rr_arbiter3
// Purely combinational three-way round-robin arbiter. The search starts at
// the source named by ptr_in and proceeds dist -> vel -> ang with wrap.
// Ports:
//   req_in       [2:0] request (valid) per source, bit order from the package
//   ptr_in       [1:0] current round-robin pointer (0..2)
//   grant_out    [2:0] one-hot grant, zero when nothing requests
//   next_ptr_out [1:0] pointer to the source after the granted one, or
//                      ptr_in unchanged when nothing is granted
// ---------------------------------------------------------------------------
module rr_arbiter3
    import display_sched_pkg::*;
(
    input  logic [2:0] req_in,
    input  logic [1:0] ptr_in,
    output logic [2:0] grant_out,
    output logic [1:0] next_ptr_out
);

    // Each pointer value fixes a search order; the first requester in that
    // order wins and the pointer moves one past it.
    always_comb begin
        grant_out    = 3'b000;
        next_ptr_out = ptr_in;
        case (ptr_in)
            2'd1: begin
                if (req_in[SRC_VEL]) begin
                    grant_out    = 3'b010;
                    next_ptr_out = 2'd2;
                end else if (req_in[SRC_ANG]) begin
                    grant_out    = 3'b100;
                    next_ptr_out = 2'd0;
                end else if (req_in[SRC_DIST]) begin
                    grant_out    = 3'b001;
                    next_ptr_out = 2'd1;
                end
            end
            2'd2: begin
                if (req_in[SRC_ANG]) begin
                    grant_out    = 3'b100;
                    next_ptr_out = 2'd0;
                end else if (req_in[SRC_DIST]) begin
                    grant_out    = 3'b001;
                    next_ptr_out = 2'd1;
                end else if (req_in[SRC_VEL]) begin
                    grant_out    = 3'b010;
                    next_ptr_out = 2'd2;
                end
            end
            default: begin
                if (req_in[SRC_DIST]) begin
                    grant_out    = 3'b001;
                    next_ptr_out = 2'd1;
                end else if (req_in[SRC_VEL]) begin
                    grant_out    = 3'b010;
                    next_ptr_out = 2'd2;
                end else if (req_in[SRC_ANG]) begin
                    grant_out    = 3'b100;
                    next_ptr_out = 2'd0;
                end
            end
        endcase
    end

endmodule

// File: rtl/display_update_scheduler.sv
// ---------------------------------------------------------------------------
// display_update_scheduler
// Collects range, velocity and angle samples through a round-robin arbitrated
// shadow register, clamps them to displayable ranges and commits the shadow to
// the display outputs at a fixed period. Fires a one-shot trigger once every
// source has reported and flags sources that stopped reporting.
// Ports:
//   clk_in, rst_in                    clock, async active-high reset
//   dist_valid_in/dist_in/dist_ready_out      range sample handshake (cm)
//   vel_valid_in/vel_in/vel_toward_in/vel_ready_out  velocity handshake
//   ang_valid_in/ang_in/ang_ready_out         signed angle handshake
//   distance_out, velocity_out, towards_observer_out, angle_out  committed values
//   trigger_out                       one-cycle pulse on entering RUN
//   commit_out                        one-cycle pulse per periodic commit
//   stale_out[2:0]                    per-source stale flags (dist, vel, ang)
// ---------------------------------------------------------------------------
module display_update_scheduler
    import display_sched_pkg::*;
#(
    parameter int COMMIT_PERIOD = 10_000_000,
    parameter int STALE_PERIOD  = 50_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        dist_valid_in,
    input  logic [15:0] dist_in,
    output logic        dist_ready_out,
    input  logic        vel_valid_in,
    input  logic [15:0] vel_in,
    input  logic        vel_toward_in,
    output logic        vel_ready_out,
    input  logic        ang_valid_in,
    input  logic [7:0]  ang_in,
    output logic        ang_ready_out,
    output logic [15:0] distance_out,
    output logic [15:0] velocity_out,
    output logic        towards_observer_out,
    output logic [7:0]  angle_out,
    output logic        trigger_out,
    output logic        commit_out,
    output logic [2:0]  stale_out
);

    localparam int CW = (COMMIT_PERIOD > 1) ? $clog2(COMMIT_PERIOD) : 1;
    localparam int SW = $clog2(STALE_PERIOD + 1);
    localparam logic [CW-1:0] COMMIT_LAST = CW'(COMMIT_PERIOD - 1);
    localparam logic [SW-1:0] STALE_SAT   = SW'(STALE_PERIOD);

    logic [2:0]  valid_vec;
    logic [2:0]  grant;
    logic [2:0]  accept;
    logic [1:0]  next_ptr;

    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] dist_sh_q, dist_sh_d;
    logic [15:0] vel_sh_q, vel_sh_d;
    logic        toward_sh_q, toward_sh_d;
    logic [7:0]  ang_sh_q, ang_sh_d;

    logic [NUM_SRC-1:0][SW-1:0] stale_cnt_q, stale_cnt_d;
    logic [NUM_SRC-1:0]         stale_q, stale_d;

    sched_state_t state_q, state_d;
    logic [2:0]   seen_q, seen_d;
    logic [CW-1:0] commit_cnt_q, commit_cnt_d;

    logic [15:0] distance_q, distance_d;
    logic [15:0] velocity_q, velocity_d;
    logic        towards_q, towards_d;
    logic [7:0]  angle_q, angle_d;
    logic        trigger_q, trigger_d;
    logic        commit_q, commit_d;

    assign valid_vec = {ang_valid_in, vel_valid_in, dist_valid_in};

    rr_arbiter3 u_rr_arbiter3 (
        .req_in       (valid_vec),
        .ptr_in       (rr_ptr_q),
        .grant_out    (grant),
        .next_ptr_out (next_ptr)
    );

    // Readies are masked by reset directly so that no producer sees a
    // handshake while reset is held, even between clock edges.
    assign accept         = grant & {3{~rst_in}};
    assign dist_ready_out = accept[SRC_DIST];
    assign vel_ready_out  = accept[SRC_VEL];
    assign ang_ready_out  = accept[SRC_ANG];

    // Shadow register write port: the granted source writes its clamped value
    // and the pointer moves past it.
    always_comb begin
        dist_sh_d   = dist_sh_q;
        vel_sh_d    = vel_sh_q;
        toward_sh_d = toward_sh_q;
        ang_sh_d    = ang_sh_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept[SRC_DIST]) begin
            dist_sh_d = clamp_u16(dist_in, DIST_MAX);
        end
        if (accept[SRC_VEL]) begin
            vel_sh_d    = clamp_u16(vel_in, VEL_MAX);
            toward_sh_d = vel_toward_in;
        end
        if (accept[SRC_ANG]) begin
            ang_sh_d = clamp_angle(ang_in);
        end
        if (|accept) begin
            rr_ptr_d = next_ptr;
        end
    end

    // Stale counters saturate rather than wrap; an accept always wins, even
    // on the edge that would have saturated the counter. The flag is derived
    // from the next count so it drops the cycle right after an accept.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        stale_d     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                stale_cnt_d[i] = '0;
            end else if (stale_cnt_q[i] != STALE_SAT) begin
                stale_cnt_d[i] = stale_cnt_q[i] + SW'(1);
            end
            stale_d[i] = (stale_cnt_d[i] == STALE_SAT);
        end
    end

    // Scheduler FSM. Commits always copy the registered shadow, so a sample
    // accepted on a commit edge shows up only at the following commit.
    // Losing all three sources drops back to WAIT_ALL without any pulse and
    // without touching the displayed values.
    always_comb begin
        state_d      = state_q;
        seen_d       = seen_q | accept;
        commit_cnt_d = commit_cnt_q;
        distance_d   = distance_q;
        velocity_d   = velocity_q;
        towards_d    = towards_q;
        angle_d      = angle_q;
        trigger_d    = 1'b0;
        commit_d     = 1'b0;
        case (state_q)
            WAIT_ALL: begin
                commit_cnt_d = '0;
                if (seen_q == 3'b111) begin
                    distance_d = dist_sh_q;
                    velocity_d = vel_sh_q;
                    towards_d  = toward_sh_q;
                    angle_d    = ang_sh_q;
                    trigger_d  = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stale_q == 3'b111) begin
                    state_d      = WAIT_ALL;
                    seen_d       = accept;
                    commit_cnt_d = '0;
                end else if (commit_cnt_q == COMMIT_LAST) begin
                    distance_d   = dist_sh_q;
                    velocity_d   = vel_sh_q;
                    towards_d    = toward_sh_q;
                    angle_d      = ang_sh_q;
                    commit_d     = 1'b1;
                    commit_cnt_d = '0;
                end else begin
                    commit_cnt_d = commit_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = WAIT_ALL;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q     <= 2'(SRC_DIST);
            dist_sh_q    <= '0;
            vel_sh_q     <= '0;
            toward_sh_q  <= 1'b0;
            ang_sh_q     <= '0;
            stale_cnt_q  <= '0;
            stale_q      <= '0;
            state_q      <= WAIT_ALL;
            seen_q       <= '0;
            commit_cnt_q <= '0;
            distance_q   <= '0;
            velocity_q   <= '0;
            towards_q    <= 1'b0;
            angle_q      <= '0;
            trigger_q    <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            dist_sh_q    <= dist_sh_d;
            vel_sh_q     <= vel_sh_d;
            toward_sh_q  <= toward_sh_d;
            ang_sh_q     <= ang_sh_d;
            stale_cnt_q  <= stale_cnt_d;
            stale_q      <= stale_d;
            state_q      <= state_d;
            seen_q       <= seen_d;
            commit_cnt_q <= commit_cnt_d;
            distance_q   <= distance_d;
            velocity_q   <= velocity_d;
            towards_q    <= towards_d;
            angle_q      <= angle_d;
            trigger_q    <= trigger_d;
            commit_q     <= commit_d;
        end
    end

    assign distance_out         = distance_q;
    assign velocity_out         = velocity_q;
    assign towards_observer_out = towards_q;
    assign angle_out            = angle_q;
    assign trigger_out          = trigger_q;
    assign commit_out           = commit_q;
    assign stale_out            = stale_q;

endmodule

// File: tb/tb_display_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_update_scheduler
// Scenario-driven bench for display_update_scheduler with a cycle-level
// reference model that tracks edges, last-accept times and the trigger time.
// ---------------------------------------------------------------------------
module tb_display_update_scheduler;

    localparam int P  = 8;
    localparam int SP = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dist_valid, vel_valid, vel_toward, ang_valid;
    logic [15:0] dist_v, vel_v;
    logic [7:0]  ang_v;
    logic        dist_ready, vel_ready, ang_ready;
    logic [15:0] distance_out, velocity_out;
    logic        towards_out;
    logic [7:0]  angle_out;
    logic        trigger_out, commit_out;
    logic [2:0]  stale_out;

    int total = 0;
    int bad   = 0;

    // Reference model: edge count, last-accept edge per source, trigger edge.
    int   m_now, m_ptr, m_trig_edge;
    int   m_last[3];
    bit   m_run;
    bit [2:0] m_seen, m_stale;
    int   m_sh_dist, m_sh_vel, m_sh_ang;
    bit   m_sh_tow;
    int   m_dist_o, m_vel_o, m_ang_o;
    bit   m_tow_o, m_trig, m_commit;

    always #5 clk = ~clk;

    display_update_scheduler #(.COMMIT_PERIOD(P), .STALE_PERIOD(SP)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .dist_valid_in        (dist_valid),
        .dist_in              (dist_v),
        .dist_ready_out       (dist_ready),
        .vel_valid_in         (vel_valid),
        .vel_in               (vel_v),
        .vel_toward_in        (vel_toward),
        .vel_ready_out        (vel_ready),
        .ang_valid_in         (ang_valid),
        .ang_in               (ang_v),
        .ang_ready_out        (ang_ready),
        .distance_out         (distance_out),
        .velocity_out         (velocity_out),
        .towards_observer_out (towards_out),
        .angle_out            (angle_out),
        .trigger_out          (trigger_out),
        .commit_out           (commit_out),
        .stale_out            (stale_out)
    );

    function automatic int model_grant();
        logic [2:0] v;
        int idx;
        v = {ang_valid, vel_valid, dist_valid};
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        int g;
        g = model_grant();
        if (g < 0) return 3'b000;
        return 3'(1 << g);
    endfunction

    function automatic logic [40:0] exp_outputs();
        return {16'(m_dist_o), 16'(m_vel_o), m_tow_o, 8'(m_ang_o)};
    endfunction

    task automatic model_reset();
        m_now = 0; m_ptr = 0; m_trig_edge = 0; m_run = 0;
        m_last = '{0, 0, 0};
        m_seen = '0; m_stale = '0;
        m_sh_dist = 0; m_sh_vel = 0; m_sh_ang = 0; m_sh_tow = 0;
        m_dist_o = 0; m_vel_o = 0; m_ang_o = 0; m_tow_o = 0;
        m_trig = 0; m_commit = 0;
    endtask

    task automatic model_edge();
        int g, a;
        g = model_grant();
        m_now++;
        m_trig = 0;
        m_commit = 0;
        if (!m_run) begin
            if (m_seen == 3'b111) begin
                m_dist_o = m_sh_dist; m_vel_o = m_sh_vel; m_tow_o = m_sh_tow; m_ang_o = m_sh_ang;
                m_trig = 1; m_run = 1; m_trig_edge = m_now;
            end
        end else if (m_stale == 3'b111) begin
            m_run = 0;
            m_seen = '0;
        end else if ((m_now - m_trig_edge) % P == 0) begin
            m_dist_o = m_sh_dist; m_vel_o = m_sh_vel; m_tow_o = m_sh_tow; m_ang_o = m_sh_ang;
            m_commit = 1;
        end
        if (g >= 0) begin
            if (g == 0) m_sh_dist = (int'(dist_v) > 255) ? 255 : int'(dist_v);
            if (g == 1) begin
                m_sh_vel = (int'(vel_v) > 15) ? 15 : int'(vel_v);
                m_sh_tow = vel_toward;
            end
            if (g == 2) begin
                a = int'($signed(ang_v));
                m_sh_ang = (a > 90) ? 90 : ((a < -90) ? -90 : a);
            end
            m_seen[g] = 1'b1;
            m_last[g] = m_now;
            m_ptr = (g + 1) % 3;
        end
        for (int i = 0; i < 3; i++) m_stale[i] = ((m_now - m_last[i]) >= SP);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        dist_valid = 0; vel_valid = 0; ang_valid = 0;
    endtask

    task automatic drive_all_random();
        dist_valid = 1; vel_valid = 1; ang_valid = 1;
        dist_v = 16'($urandom_range(0, 400));
        vel_v = 16'($urandom_range(0, 30));
        vel_toward = 1'($urandom);
        ang_v = 8'($urandom_range(0, 255));
        if (ang_v == 8'd45) ang_v = 8'd44;
    endtask

    task automatic test_reset();
        drive_all_random();
        #2;
        total++;
        if ({ang_ready, vel_ready, dist_ready} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_ready: got %b expected 000", {ang_ready, vel_ready, dist_ready});
        end
        total++;
        if ({distance_out, velocity_out, towards_out, angle_out, trigger_out, commit_out, stale_out} !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs: got %h expected 0",
                {distance_out, velocity_out, towards_out, angle_out, trigger_out, commit_out, stale_out});
        end
        idle();
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_first_trigger();
        int trig_cycle;
        logic [7:0] neg90;
        trig_cycle = -1;
        neg90 = 8'(-90);
        for (int c = 1; c <= 6; c++) begin
            idle();
            if (c == 1) begin dist_valid = 1; dist_v = 16'd300; end
            if (c == 2) begin vel_valid = 1; vel_v = 16'd20; vel_toward = 1; end
            if (c == 3) begin ang_valid = 1; ang_v = 8'(-100); end
            #1;
            total++;
            if ({ang_ready, vel_ready, dist_ready} !== exp_ready()) begin
                bad++; $display("[TB] FAIL first_ready c=%0d: got %b expected %b", c, {ang_ready, vel_ready, dist_ready}, exp_ready());
            end
            step();
            if (trigger_out === 1'b1) trig_cycle = c + 1;
            total++;
            if (trigger_out !== m_trig) begin
                bad++; $display("[TB] FAIL first_trigger c=%0d: got %b expected %b", c, trigger_out, m_trig);
            end
        end
        total++;
        if (trig_cycle != 5) begin
            bad++; $display("[TB] FAIL trigger_cycle: got %0d expected 5", trig_cycle);
        end
        total++;
        if ({distance_out, velocity_out, towards_out, angle_out} !== {16'd255, 16'd15, 1'b1, neg90}) begin
            bad++; $display("[TB] FAIL first_values: got %0d %0d %b %h expected 255 15 1 a6",
                distance_out, velocity_out, towards_out, angle_out);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [3];
        logic [2:0] rdy;
        exp_seq = '{3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 6; k++) begin
            drive_all_random();
            #1;
            rdy = {ang_ready, vel_ready, dist_ready};
            total++;
            if (rdy !== exp_seq[k % 3] || $countones(rdy) != 1) begin
                bad++; $display("[TB] FAIL rr_grant k=%0d: got %b expected %b", k, rdy, exp_seq[k % 3]);
            end
            step();
            total++;
            if ({trigger_out, commit_out, stale_out} !== {m_trig, m_commit, m_stale}) begin
                bad++; $display("[TB] FAIL rr_flags k=%0d: got %b expected %b", k,
                    {trigger_out, commit_out, stale_out}, {m_trig, m_commit, m_stale});
            end
        end
        idle();
    endtask

    task automatic test_commit_collision();
        int guard, old_ang;
        guard = 0;
        idle();
        while (((m_now + 1 - m_trig_edge) % P) != 0 && guard < P + 2) begin
            step();
            guard++;
        end
        total++;
        if (guard >= P + 2) begin
            bad++; $display("[TB] FAIL collision_wait: got %0d cycles expected under %0d", guard, P + 2);
        end
        old_ang = m_sh_ang;
        ang_valid = 1; ang_v = 8'd45;
        #1;
        total++;
        if (ang_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL collision_ready: got %b expected 1", ang_ready);
        end
        step();
        idle();
        total++;
        if (commit_out !== 1'b1 || angle_out !== 8'(old_ang)) begin
            bad++; $display("[TB] FAIL collision_old: got commit=%b ang=%h expected 1 %h", commit_out, angle_out, 8'(old_ang));
        end
        for (int k = 1; k <= P; k++) begin
            step();
            total++;
            if (commit_out !== (k == P)) begin
                bad++; $display("[TB] FAIL collision_pulse k=%0d: got %b expected %b", k, commit_out, (k == P));
            end
        end
        total++;
        if (angle_out !== 8'd45) begin
            bad++; $display("[TB] FAIL collision_new: got %h expected 2d", angle_out);
        end
    endtask

    task automatic test_stale_single();
        drive_all_random();
        #1;
        total++;
        if ({ang_ready, vel_ready, dist_ready} !== 3'b001) begin
            bad++; $display("[TB] FAIL stale_feed: got %b expected 001", {ang_ready, vel_ready, dist_ready});
        end
        step();
        for (int k = 1; k <= 33; k++) begin
            drive_all_random();
            dist_valid = 0;
            #1;
            total++;
            if ({ang_ready, vel_ready, dist_ready} !== exp_ready()) begin
                bad++; $display("[TB] FAIL stale_ready k=%0d: got %b expected %b", k, {ang_ready, vel_ready, dist_ready}, exp_ready());
            end
            step();
            total++;
            if ({commit_out, stale_out} !== {m_commit, m_stale}) begin
                bad++; $display("[TB] FAIL stale_track k=%0d: got %b expected %b", k, {commit_out, stale_out}, {m_commit, m_stale});
            end
            if (k == 31) begin
                total++;
                if (stale_out !== 3'b000) begin
                    bad++; $display("[TB] FAIL stale_early: got %b expected 000", stale_out);
                end
            end
        end
        total++;
        if (stale_out !== 3'b001) begin
            bad++; $display("[TB] FAIL stale_dist: got %b expected 001", stale_out);
        end
        idle();
        dist_valid = 1; dist_v = 16'd42;
        #1;
        step();
        idle();
        total++;
        if (stale_out !== 3'b000 || distance_out !== 16'(m_dist_o)) begin
            bad++; $display("[TB] FAIL stale_clear: got %b dist=%0d expected 000 dist=%0d", stale_out, distance_out, m_dist_o);
        end
    endtask

    task automatic test_all_stale();
        int pulses;
        idle();
        for (int k = 0; k < 40; k++) begin
            step();
            total++;
            if ({trigger_out, commit_out, stale_out, distance_out, velocity_out, towards_out, angle_out}
                !== {m_trig, m_commit, m_stale, exp_outputs()}) begin
                bad++; $display("[TB] FAIL all_stale k=%0d: got %b/%h expected %b/%h", k,
                    {trigger_out, commit_out, stale_out}, {distance_out, velocity_out, towards_out, angle_out},
                    {m_trig, m_commit, m_stale}, exp_outputs());
            end
        end
        total++;
        if (stale_out !== 3'b111) begin
            bad++; $display("[TB] FAIL all_stale_flags: got %b expected 111", stale_out);
        end
        pulses = 0;
        for (int k = 0; k < 2 * P; k++) begin
            step();
            pulses += int'(commit_out) + int'(trigger_out);
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("[TB] FAIL wait_all_quiet: got %0d pulses expected 0", pulses);
        end
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) drive_all_random(); else idle();
            #1;
            step();
            pulses += int'(trigger_out);
            total++;
            if ({trigger_out, stale_out, distance_out, velocity_out, towards_out, angle_out}
                !== {m_trig, m_stale, exp_outputs()}) begin
                bad++; $display("[TB] FAIL refeed k=%0d: got %b/%h expected %b/%h", k,
                    {trigger_out, stale_out}, {distance_out, velocity_out, towards_out, angle_out},
                    {m_trig, m_stale}, exp_outputs());
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("[TB] FAIL retrigger: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        drive_all_random();
        step();
        #2;
        rst = 1;
        #1;
        total++;
        if ({distance_out, velocity_out, towards_out, angle_out, trigger_out, commit_out, stale_out} !== '0) begin
            bad++; $display("[TB] FAIL async_outputs: got %h expected 0",
                {distance_out, velocity_out, towards_out, angle_out, trigger_out, commit_out, stale_out});
        end
        total++;
        if ({ang_ready, vel_ready, dist_ready} !== 3'b000) begin
            bad++; $display("[TB] FAIL async_ready: got %b expected 000", {ang_ready, vel_ready, dist_ready});
        end
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        total++;
        if ({ang_ready, vel_ready, dist_ready} !== 3'b001) begin
            bad++; $display("[TB] FAIL post_reset_grant: got %b expected 001", {ang_ready, vel_ready, dist_ready});
        end
        step();
        idle();
    endtask

    task automatic test_random();
        bit quiet;
        for (int c = 0; c < 300; c++) begin
            quiet = (c % 100) >= 60;
            dist_valid = !quiet && ($urandom_range(0, 3) == 0);
            vel_valid = !quiet && ($urandom_range(0, 3) == 0);
            ang_valid = !quiet && ($urandom_range(0, 3) == 0);
            dist_v = 16'($urandom);
            vel_v = 16'($urandom_range(0, 40));
            vel_toward = 1'($urandom);
            ang_v = 8'($urandom);
            #1;
            total++;
            if ({ang_ready, vel_ready, dist_ready} !== exp_ready()) begin
                bad++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, {ang_ready, vel_ready, dist_ready}, exp_ready());
            end
            step();
            total++;
            if ({trigger_out, commit_out, stale_out} !== {m_trig, m_commit, m_stale}) begin
                bad++; $display("[TB] FAIL rand_flags c=%0d: got %b expected %b", c,
                    {trigger_out, commit_out, stale_out}, {m_trig, m_commit, m_stale});
            end
            total++;
            if ({distance_out, velocity_out, towards_out, angle_out} !== exp_outputs()) begin
                bad++; $display("[TB] FAIL rand_values c=%0d: got %h expected %h", c,
                    {distance_out, velocity_out, towards_out, angle_out}, exp_outputs());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        dist_v = '0; vel_v = '0; vel_toward = 0; ang_v = '0;
        model_reset();
        test_reset();
        test_first_trigger();
        test_round_robin();
        test_commit_collision();
        test_stale_single();
        test_all_stale();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
